// File: rtl/odd_issue_sched_if.sv
// Request/status bundle between the odd-pipe issue stage (master) and the scheduler (slave).
interface odd_issue_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  unit;
    logic [6:0]  rt_addr;
    logic        reg_write;
    logic [6:0]  ra_odd_addr, rb_odd_addr, rc_odd_addr;
    logic        is_ra_odd_valid, is_rb_odd_valid, is_rc_odd_valid;
    logic [6:0]  ra_even_addr, rb_even_addr, rc_even_addr;
    logic        is_ra_even_valid, is_rb_even_valid, is_rc_even_valid;
    logic        even_valid;
    logic        flush;
    logic        issue;
    logic [1:0]  issue_unit;
    logic        stall_odd_raw, stall_even_raw, stall_struct;
    logic [15:0] stall_cnt;

    modport master (
        output in_valid, unit, rt_addr, reg_write,
               ra_odd_addr, rb_odd_addr, rc_odd_addr,
               is_ra_odd_valid, is_rb_odd_valid, is_rc_odd_valid,
               ra_even_addr, rb_even_addr, rc_even_addr,
               is_ra_even_valid, is_rb_even_valid, is_rc_even_valid,
               even_valid, flush,
        input  in_ready, issue, issue_unit,
               stall_odd_raw, stall_even_raw, stall_struct, stall_cnt
    );

    modport slave (
        input  in_valid, unit, rt_addr, reg_write,
               ra_odd_addr, rb_odd_addr, rc_odd_addr,
               is_ra_odd_valid, is_rb_odd_valid, is_rc_odd_valid,
               ra_even_addr, rb_even_addr, rc_even_addr,
               is_ra_even_valid, is_rb_even_valid, is_rc_even_valid,
               even_valid, flush,
        output in_ready, issue, issue_unit,
               stall_odd_raw, stall_even_raw, stall_struct, stall_cnt
    );
endinterface

// File: rtl/odd_issue_sched.sv
// Odd-pipe issue scheduler: tracks in-flight producers by age, detects RAW and
// writeback-port conflicts combinationally, and counts stall cycles.
module odd_issue_sched #(
    parameter int unsigned P_LAT_PERM = 4,
    parameter int unsigned P_LAT_LS   = 6,
    parameter int unsigned P_LAT_BR   = 1,
    parameter int unsigned P_DEPTH    = 7
) (
    input logic              clk,
    input logic              reset,
    odd_issue_sched_if.slave bus
);
    localparam int unsigned LAT_W = 8;

    typedef struct packed {
        logic             valid;
        logic [6:0]       rt;
        logic             wr;
        logic [LAT_W-1:0] lat;
    } stage_t;

    stage_t           stage_q [1:P_DEPTH];
    stage_t           stage_d [1:P_DEPTH];
    logic [P_DEPTH:1] pend;
    logic [15:0]      cnt_q, cnt_d;
    logic [LAT_W-1:0] req_lat;
    logic             odd_raw, even_raw, struct_hit, ready, issue_w;

    always_comb begin
        case (bus.unit)
            2'd1:    req_lat = LAT_W'(P_LAT_LS);
            2'd2:    req_lat = LAT_W'(P_LAT_BR);
            default: req_lat = LAT_W'(P_LAT_PERM);
        endcase
    end

    // A stage-k producer is still outside forwarding reach while k < its latency.
    always_comb begin
        pend = '0;
        for (int unsigned k = 1; k <= P_DEPTH; k++)
            pend[k] = stage_q[k].valid && stage_q[k].wr && (k < 32'(stage_q[k].lat));
    end

    always_comb begin
        odd_raw    = 1'b0;
        even_raw   = 1'b0;
        struct_hit = 1'b0;
        for (int unsigned k = 1; k <= P_DEPTH; k++) begin
            if (pend[k]) begin
                if ((bus.is_ra_odd_valid && bus.ra_odd_addr == stage_q[k].rt) ||
                    (bus.is_rb_odd_valid && bus.rb_odd_addr == stage_q[k].rt) ||
                    (bus.is_rc_odd_valid && bus.rc_odd_addr == stage_q[k].rt))
                    odd_raw = 1'b1;
                if ((bus.is_ra_even_valid && bus.ra_even_addr == stage_q[k].rt) ||
                    (bus.is_rb_even_valid && bus.rb_even_addr == stage_q[k].rt) ||
                    (bus.is_rc_even_valid && bus.rc_even_addr == stage_q[k].rt))
                    even_raw = 1'b1;
            end
            // Same writeback cycle: lat_k - k == req_lat, rearranged to stay unsigned.
            if (stage_q[k].valid && stage_q[k].wr &&
                32'(stage_q[k].lat) == 32'(req_lat) + k)
                struct_hit = 1'b1;
        end
        odd_raw    = odd_raw && bus.in_valid && reset;
        even_raw   = even_raw && bus.even_valid && reset;
        struct_hit = struct_hit && bus.in_valid && bus.reg_write && reset;
        ready      = reset && !(odd_raw || even_raw || struct_hit || bus.flush);
        issue_w    = bus.in_valid && ready;
    end

    always_comb begin
        stage_d[1] = '{valid: issue_w, rt: bus.rt_addr, wr: bus.reg_write, lat: req_lat};
        for (int unsigned k = 2; k <= P_DEPTH; k++)
            stage_d[k] = stage_q[k-1];
        cnt_d = cnt_q;
        if (bus.in_valid && !bus.flush && !ready && cnt_q != '1)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 1; k <= P_DEPTH; k++)
                stage_q[k] <= '0;
            cnt_q <= '0;
        end else begin
            for (int unsigned k = 1; k <= P_DEPTH; k++)
                stage_q[k] <= stage_d[k];
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready       = ready;
    assign bus.issue          = issue_w;
    assign bus.issue_unit     = (issue_w && bus.unit != 2'd3) ? bus.unit : 2'd0;
    assign bus.stall_odd_raw  = odd_raw;
    assign bus.stall_even_raw = even_raw;
    assign bus.stall_struct   = struct_hit;
    assign bus.stall_cnt      = cnt_q;
endmodule

// File: tb/tb_odd_issue_sched.sv
// Bench for odd_issue_sched: directed scenarios plus randomized traffic against
// a writeback-time model of in-flight producers.
module tb_odd_issue_sched;
    localparam int unsigned DEPTH = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    odd_issue_sched_if bus ();

    odd_issue_sched #(
        .P_LAT_PERM(4), .P_LAT_LS(6), .P_LAT_BR(1), .P_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int unsigned cyc;
        bit [6:0]    rt;
        bit          rw;
        int unsigned lat;
    } rec_t;

    rec_t        hist[$];
    int unsigned now;
    int unsigned model_stalls;
    int unsigned n_cmp;
    int unsigned n_fail;

    function automatic int unsigned lat_of(input logic [1:0] u);
        case (u)
            2'd1:    return 6;
            2'd2:    return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [15:0] exp_cnt();
        return (model_stalls > 65535) ? 16'hFFFF : 16'(model_stalls);
    endfunction

    // A producer blocks readers until it reaches its result cycle; two writers clash
    // when they would retire in the same cycle.
    function automatic void model_eval(output bit e_odd, output bit e_even,
                                       output bit e_struct, output bit e_ready,
                                       output bit e_issue);
        int unsigned age;
        e_odd = 0; e_even = 0; e_struct = 0; e_ready = 0; e_issue = 0;
        if (reset !== 1'b1) return;
        foreach (hist[i]) begin
            age = now - hist[i].cyc;
            if (age < 1 || age > DEPTH) continue;
            if (hist[i].rw && age < hist[i].lat) begin
                if (bus.in_valid &&
                    ((bus.is_ra_odd_valid && bus.ra_odd_addr == hist[i].rt) ||
                     (bus.is_rb_odd_valid && bus.rb_odd_addr == hist[i].rt) ||
                     (bus.is_rc_odd_valid && bus.rc_odd_addr == hist[i].rt)))
                    e_odd = 1;
                if (bus.even_valid &&
                    ((bus.is_ra_even_valid && bus.ra_even_addr == hist[i].rt) ||
                     (bus.is_rb_even_valid && bus.rb_even_addr == hist[i].rt) ||
                     (bus.is_rc_even_valid && bus.rc_even_addr == hist[i].rt)))
                    e_even = 1;
            end
            if (bus.in_valid && bus.reg_write && hist[i].rw &&
                hist[i].cyc + hist[i].lat == now + lat_of(bus.unit))
                e_struct = 1;
        end
        e_ready = !(e_odd || e_even || e_struct || bus.flush);
        e_issue = bus.in_valid && e_ready;
    endfunction

    task automatic tick();
        bit o, e, s, r, i;
        model_eval(o, e, s, r, i);
        if (reset === 1'b1) begin
            if (i) hist.push_back('{now, bus.rt_addr, bus.reg_write, lat_of(bus.unit)});
            if (bus.in_valid && !bus.flush && !r) model_stalls++;
        end else begin
            hist.delete();
            model_stalls = 0;
        end
        @(posedge clk);
        now++;
        @(negedge clk);
        while (hist.size() > 0 && now - hist[0].cyc > DEPTH) void'(hist.pop_front());
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.unit = 0; bus.rt_addr = 0; bus.reg_write = 0;
        bus.ra_odd_addr = 0; bus.rb_odd_addr = 0; bus.rc_odd_addr = 0;
        bus.is_ra_odd_valid = 0; bus.is_rb_odd_valid = 0; bus.is_rc_odd_valid = 0;
        bus.ra_even_addr = 0; bus.rb_even_addr = 0; bus.rc_even_addr = 0;
        bus.is_ra_even_valid = 0; bus.is_rb_even_valid = 0; bus.is_rc_even_valid = 0;
        bus.even_valid = 0; bus.flush = 0;
    endtask

    task automatic req(input logic [1:0] u, input logic [6:0] rt, input logic rw);
        idle();
        bus.in_valid = 1; bus.unit = u; bus.rt_addr = rt; bus.reg_write = rw;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        hist.delete();
        model_stalls = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        req(2'd0, 7'd3, 1'b1);
        bus.even_valid = 1;
        #2;
        n_cmp++;
        if ({bus.issue, bus.in_ready, bus.stall_odd_raw, bus.stall_even_raw, bus.stall_struct} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000", {bus.issue, bus.in_ready,
                     bus.stall_odd_raw, bus.stall_even_raw, bus.stall_struct});
        end
        n_cmp++;
        if (bus.stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_odd_raw();
        do_reset();
        req(2'd0, 7'd5, 1'b1);
        #2;
        n_cmp++;
        if (bus.issue !== 1'b1) begin n_fail++; $display("FAIL raw_prod_issue: got %b want 1", bus.issue); end
        tick();
        req(2'd0, 7'd20, 1'b1);
        bus.ra_odd_addr = 7'd5; bus.is_ra_odd_valid = 1;
        for (int unsigned c = 1; c <= 4; c++) begin
            #2;
            n_cmp++;
            if (bus.stall_odd_raw !== (c <= 3) || bus.issue !== (c == 4)) begin
                n_fail++;
                $display("FAIL raw_cycle%0d: got stall=%b issue=%b want stall=%b issue=%b",
                         c, bus.stall_odd_raw, bus.issue, c <= 3, c == 4);
            end
            tick();
        end
        idle();
        #2;
        n_cmp++;
        if (bus.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL raw_cnt: got %0d want 3", bus.stall_cnt); end
        tick();
    endtask

    task automatic test_struct();
        do_reset();
        req(2'd1, 7'd9, 1'b1);
        tick();
        idle();
        tick();
        req(2'd0, 7'd10, 1'b1);
        #2;
        n_cmp++;
        if (bus.stall_struct !== 1'b1 || bus.issue !== 1'b0 || bus.stall_odd_raw !== 1'b0) begin
            n_fail++;
            $display("FAIL struct_c2: got struct=%b issue=%b raw=%b want 1 0 0",
                     bus.stall_struct, bus.issue, bus.stall_odd_raw);
        end
        tick();
        #2;
        n_cmp++;
        if (bus.stall_struct !== 1'b0 || bus.issue !== 1'b1) begin
            n_fail++;
            $display("FAIL struct_c3: got struct=%b issue=%b want 0 1", bus.stall_struct, bus.issue);
        end
        tick();
        idle();
    endtask

    task automatic test_branch_fwd();
        do_reset();
        req(2'd2, 7'd2, 1'b1);
        tick();
        req(2'd3, 7'd3, 1'b1);
        bus.rb_odd_addr = 7'd2; bus.is_rb_odd_valid = 1;
        #2;
        n_cmp++;
        if (bus.issue !== 1'b1 || bus.stall_odd_raw !== 1'b0 || bus.issue_unit !== 2'd0) begin
            n_fail++;
            $display("FAIL branch_fwd: got issue=%b raw=%b unit=%0d want 1 0 0",
                     bus.issue, bus.stall_odd_raw, bus.issue_unit);
        end
        tick();
        idle();
    endtask

    task automatic test_even_raw();
        do_reset();
        req(2'd1, 7'd7, 1'b1);
        tick();
        idle();
        bus.even_valid = 1; bus.rc_even_addr = 7'd7; bus.is_rc_even_valid = 1;
        for (int unsigned c = 1; c <= 6; c++) begin
            #2;
            n_cmp++;
            if (bus.stall_even_raw !== (c <= 5) || bus.in_ready !== (c > 5)) begin
                n_fail++;
                $display("FAIL even_cycle%0d: got stall=%b ready=%b want stall=%b ready=%b",
                         c, bus.stall_even_raw, bus.in_ready, c <= 5, c > 5);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush_reset();
        do_reset();
        req(2'd0, 7'd5, 1'b1);
        tick();
        req(2'd0, 7'd6, 1'b1);
        bus.ra_odd_addr = 7'd5; bus.is_ra_odd_valid = 1; bus.flush = 1;
        #2;
        n_cmp++;
        if (bus.issue !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_issue: got issue=%b ready=%b want 0 0", bus.issue, bus.in_ready);
        end
        tick();
        #2;
        n_cmp++;
        if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", bus.stall_cnt); end
        bus.flush = 0;
        tick();
        reset = 0;
        hist.delete();
        model_stalls = 0;
        #2;
        n_cmp++;
        if ({bus.stall_odd_raw, bus.issue, bus.in_ready} !== 3'b000 || bus.stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midstall_reset: got raw=%b issue=%b ready=%b cnt=%0d want 0 0 0 0",
                     bus.stall_odd_raw, bus.issue, bus.in_ready, bus.stall_cnt);
        end
        tick();
        reset = 1;
        #2;
        n_cmp++;
        if (bus.issue !== 1'b1 || bus.stall_odd_raw !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_issue: got issue=%b raw=%b want 1 0", bus.issue, bus.stall_odd_raw);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        bit eo, ee, es, er, ei;
        bit fresh;
        do_reset();
        fresh = 1;
        for (int unsigned n = 0; n < 3000; n++) begin
            reset = 1;
            if (fresh) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.unit = 2'($urandom_range(0, 3));
                bus.rt_addr = 7'($urandom_range(0, 7));
                bus.reg_write = ($urandom_range(0, 3) != 0);
                bus.ra_odd_addr = 7'($urandom_range(0, 7)); bus.is_ra_odd_valid = 1'($urandom);
                bus.rb_odd_addr = 7'($urandom_range(0, 7)); bus.is_rb_odd_valid = 1'($urandom);
                bus.rc_odd_addr = 7'($urandom_range(0, 7)); bus.is_rc_odd_valid = 1'($urandom);
                bus.ra_even_addr = 7'($urandom_range(0, 7)); bus.is_ra_even_valid = 1'($urandom);
                bus.rb_even_addr = 7'($urandom_range(0, 7)); bus.is_rb_even_valid = 1'($urandom);
                bus.rc_even_addr = 7'($urandom_range(0, 7)); bus.is_rc_even_valid = 1'($urandom);
                bus.even_valid = ($urandom_range(0, 2) == 0);
            end
            bus.flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 0;
                hist.delete();
                model_stalls = 0;
            end
            #2;
            model_eval(eo, ee, es, er, ei);
            n_cmp++;
            if ({bus.stall_odd_raw, bus.stall_even_raw, bus.stall_struct, bus.in_ready, bus.issue} !==
                {eo, ee, es, er, ei}) begin
                n_fail++;
                $display("FAIL rand_flags@%0d: got odd/even/struct/ready/issue=%b want %b", now,
                         {bus.stall_odd_raw, bus.stall_even_raw, bus.stall_struct, bus.in_ready, bus.issue},
                         {eo, ee, es, er, ei});
            end
            n_cmp++;
            if (bus.stall_cnt !== exp_cnt()) begin
                n_fail++; $display("FAIL rand_cnt@%0d: got %0d want %0d", now, bus.stall_cnt, exp_cnt());
            end
            if (ei) begin
                n_cmp++;
                if (bus.issue_unit !== ((bus.unit == 2'd3) ? 2'd0 : bus.unit)) begin
                    n_fail++; $display("FAIL rand_unit@%0d: got %0d unit_in %0d", now, bus.issue_unit, bus.unit);
                end
            end
            fresh = !bus.in_valid || ei;
            tick();
        end
        reset = 1;
        idle();
    endtask

    task automatic test_saturation();
        bit mid_done;
        do_reset();
        mid_done = 0;
        req(2'd1, 7'd1, 1'b1);
        bus.ra_odd_addr = 7'd1; bus.is_ra_odd_valid = 1;
        while (model_stalls < 65540) begin
            #2;
            if (!mid_done && model_stalls == 60000) begin
                mid_done = 1;
                n_cmp++;
                if (bus.stall_cnt !== 16'd60000) begin
                    n_fail++; $display("FAIL sat_mid: got %0d want 60000", bus.stall_cnt);
                end
            end
            tick();
        end
        #2;
        n_cmp++;
        if (bus.stall_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: got %h want ffff", bus.stall_cnt);
        end
        tick();
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        now = 0;
        model_stalls = 0;
        reset = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_odd_raw();
        test_struct();
        test_branch_fwd();
        test_even_raw();
        test_flush_reset();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
